// File: rtl/id_ex_elastic_stage.sv
// ID->EX elastic pipeline stage with a two-entry skid buffer (MAIN + SKID).
// MAIN drives the outputs and SKID catches the one beat that can arrive
// while EX is stalled. In_Ready is registered, so no combinational path runs
// from Out_Ready back to In_Ready. The destination register (instr[11:7]) and
// func3 (instr[14:12]) are decoded when an entry is captured and stored with it.
//
// Handshake: a beat transfers on the upstream side when In_Valid & In_Ready
// are both high at a rising CLK edge, and on the downstream side when
// Out_Valid & Out_Ready are both high. Once Out_Valid is asserted, it and the
// head payload hold steady until they are popped or flushed. Reset (active-low,
// synchronous) takes priority over Flush, and Flush takes priority over both
// handshakes.
module id_ex_elastic_stage #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 14,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    Flush,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [CTRL_W-1:0]       In_Ctrl,
  input  logic [XLEN-1:0]         In_PC,
  input  logic [XLEN-1:0]         In_PC_next,
  input  logic [NUM_SRC*XLEN-1:0] In_Data,
  input  logic [XLEN-1:0]         In_Immediate_value,
  input  logic [XLEN-1:0]         In_instruction,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [CTRL_W-1:0]       Out_Ctrl,
  output logic [XLEN-1:0]         Out_PC,
  output logic [XLEN-1:0]         Out_PC_next,
  output logic [NUM_SRC*XLEN-1:0] Out_Data,
  output logic [XLEN-1:0]         Out_Immediate_value,
  output logic [4:0]              Out_WriteAddress,
  output logic [2:0]              Out_func3,
  output logic [1:0]              Out_Occupancy,
  output logic [CNT_W-1:0]        Out_Stall_Count,
  output logic [1:0]              dbg_state
);

  // One stored entry: ctrl, pc, pc_next, operands, immediate, rd, func3.
  localparam int PW = CTRL_W + 3 * XLEN + NUM_SRC * XLEN + 5 + 3;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The state encoding equals the number of entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     main_q, main_d;
  logic [PW-1:0]     skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              out_valid;
  logic              accept;
  logic              pop;
  logic [PW-1:0]     in_pack;
  logic [CTRL_W-1:0] main_ctrl;
  logic              unused_instr_bits;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = In_Valid & in_ready_q;
  assign pop       = out_valid & Out_Ready;

  assign in_pack = {In_Ctrl, In_PC, In_PC_next, In_Data, In_Immediate_value,
                    In_instruction[11:7], In_instruction[14:12]};

  // Only rd and func3 are kept from the instruction word.
  assign unused_instr_bits = ^{In_instruction[XLEN-1:15], In_instruction[6:0]};

  // Next-state, payload movement, registered ready and stall counter.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_pack;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d = in_pack;
        end else if (accept) begin
          skid_d  = in_pack;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // In_Ready is low here, so nothing new can arrive.
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops everything, including a beat arriving this cycle. The
    // payload is left alone because it is don't-care while Out_Valid is low.
    if (Flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    in_ready_d = (state_d != ST_FULL);

    if (out_valid && !Out_Ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {main_ctrl, Out_PC, Out_PC_next, Out_Data, Out_Immediate_value,
          Out_WriteAddress, Out_func3} = main_q;

  assign Out_Ctrl        = out_valid ? main_ctrl : '0;
  assign Out_Valid       = out_valid;
  assign In_Ready        = in_ready_q;
  assign Out_Occupancy   = state_q;
  assign Out_Stall_Count = stall_cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// Bench for id_ex_elastic_stage: a constant-expectation vector table, directed
// corner sequences and randomized traffic checked each cycle against a
// queue-based reference model. A second instance with CNT_W=3 shares all
// inputs, so the saturation of its stall counter can be observed.
module tb_id_ex_elastic_stage;

  typedef struct packed {
    logic [13:0] ctrl;
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [63:0] data;
    logic [31:0] imm;
    logic [31:0] instr;
  } beat_t;

  typedef struct {
    bit          flush;
    bit          in_valid;
    bit          out_ready;
    logic [31:0] pc;
    bit          exp_valid;
    logic [31:0] exp_pc;
    int          exp_occ;
    bit          exp_in_ready;
  } vec_t;

  // ---------------- clock / reset / signals ----------------
  logic clk;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic out_ready;
  beat_t cur;

  logic        in_ready, out_valid;
  logic [13:0] out_ctrl;
  logic [31:0] out_pc, out_pcn, out_imm;
  logic [63:0] out_data;
  logic [4:0]  out_wa;
  logic [2:0]  out_f3;
  logic [1:0]  out_occ, dbg_st;
  logic [15:0] out_cnt;

  logic        s_in_ready, s_out_valid;
  logic [13:0] s_out_ctrl;
  logic [31:0] s_out_pc, s_out_pcn, s_out_imm;
  logic [63:0] s_out_data;
  logic [4:0]  s_out_wa;
  logic [2:0]  s_out_f3;
  logic [1:0]  s_out_occ, s_dbg_st;
  logic [2:0]  s_out_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  id_ex_elastic_stage #(.XLEN(32), .CTRL_W(14), .NUM_SRC(2), .CNT_W(16)) dut (
    .CLK(clk), .Reset(rst_n), .Flush(flush),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .In_Ctrl(cur.ctrl), .In_PC(cur.pc), .In_PC_next(cur.pcn),
    .In_Data(cur.data), .In_Immediate_value(cur.imm), .In_instruction(cur.instr),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Ctrl(out_ctrl), .Out_PC(out_pc), .Out_PC_next(out_pcn),
    .Out_Data(out_data), .Out_Immediate_value(out_imm),
    .Out_WriteAddress(out_wa), .Out_func3(out_f3),
    .Out_Occupancy(out_occ), .Out_Stall_Count(out_cnt), .dbg_state(dbg_st)
  );

  id_ex_elastic_stage #(.XLEN(32), .CTRL_W(14), .NUM_SRC(2), .CNT_W(3)) dut_s (
    .CLK(clk), .Reset(rst_n), .Flush(flush),
    .In_Valid(in_valid), .In_Ready(s_in_ready),
    .In_Ctrl(cur.ctrl), .In_PC(cur.pc), .In_PC_next(cur.pcn),
    .In_Data(cur.data), .In_Immediate_value(cur.imm), .In_instruction(cur.instr),
    .Out_Valid(s_out_valid), .Out_Ready(out_ready),
    .Out_Ctrl(s_out_ctrl), .Out_PC(s_out_pc), .Out_PC_next(s_out_pcn),
    .Out_Data(s_out_data), .Out_Immediate_value(s_out_imm),
    .Out_WriteAddress(s_out_wa), .Out_func3(s_out_f3),
    .Out_Occupancy(s_out_occ), .Out_Stall_Count(s_out_cnt), .dbg_state(s_dbg_st)
  );

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: FIFO of beats, capacity 2, with a registered ready.
  beat_t exp_q[$];
  bit    m_ir;
  int    m_cnt;
  int    m_cnt_s;

  task automatic model_edge();
    bit pop_now;
    bit acc_now;
    beat_t dropped;
    if (!rst_n) begin
      exp_q.delete();
      m_ir    = 1'b0;
      m_cnt   = 0;
      m_cnt_s = 0;
    end else begin
      pop_now = (exp_q.size() > 0) && out_ready;
      acc_now = in_valid && m_ir;
      if (exp_q.size() > 0 && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 7) m_cnt_s++;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop_now) dropped = exp_q.pop_front();
        if (acc_now) exp_q.push_back(cur);
      end
      m_ir = (exp_q.size() < 2);
    end
  endtask

  task automatic check_model();
    beat_t b;
    chk("valid", out_valid, exp_q.size() != 0);
    chk("occupancy", out_occ, exp_q.size());
    chk("state", dbg_st, exp_q.size());
    chk("in_ready", in_ready, m_ir);
    chk("stall_count", out_cnt, m_cnt);
    chk("s_stall_count", s_out_cnt, m_cnt_s);
    chk("s_valid", s_out_valid, exp_q.size() != 0);
    if (exp_q.size() > 0) begin
      b = exp_q[0];
      chk("ctrl", out_ctrl, b.ctrl);
      chk("pc", out_pc, b.pc);
      chk("pc_next", out_pcn, b.pcn);
      chk("data", out_data, b.data);
      chk("imm", out_imm, b.imm);
      chk("write_addr", out_wa, b.instr[11:7]);
      chk("func3", out_f3, b.instr[14:12]);
    end else begin
      chk("ctrl_bubble", out_ctrl, 14'd0);
      chk("s_ctrl_bubble", s_out_ctrl, 14'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.ctrl  = 14'($urandom);
    b.pc    = $urandom;
    b.pcn   = $urandom;
    b.data  = {$urandom, $urandom};
    b.imm   = $urandom;
    b.instr = $urandom;
    return b;
  endfunction

  function automatic beat_t pc_beat(input logic [31:0] pc);
    beat_t b;
    b = rand_beat();
    b.pc  = pc;
    b.pcn = pc + 32'd4;
    return b;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_ctrl"}, out_ctrl, 14'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_pc_next"}, out_pcn, 32'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_imm"}, out_imm, 32'd0);
    chk({tag, "_wa"}, out_wa, 5'd0);
    chk({tag, "_f3"}, out_f3, 3'd0);
    chk({tag, "_occ"}, out_occ, 2'd0);
    chk({tag, "_cnt"}, out_cnt, 16'd0);
    chk({tag, "_s_cnt"}, s_out_cnt, 3'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[13];

  initial begin
    beat_t a;
    beat_t b;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cur = '0;

    // Vector table, starting from EMPTY with In_Ready=1.
    vecs[0]  = '{0, 1, 1, 32'h100, 1, 32'h100, 1, 1};
    vecs[1]  = '{0, 1, 0, 32'h104, 1, 32'h100, 2, 0};
    vecs[2]  = '{0, 1, 0, 32'h108, 1, 32'h100, 2, 0};
    vecs[3]  = '{0, 0, 1, 32'h000, 1, 32'h104, 1, 1};
    vecs[4]  = '{0, 1, 1, 32'h10C, 1, 32'h10C, 1, 1};
    vecs[5]  = '{0, 0, 1, 32'h000, 0, 32'h000, 0, 1};
    vecs[6]  = '{0, 1, 0, 32'h110, 1, 32'h110, 1, 1};
    vecs[7]  = '{0, 1, 0, 32'h114, 1, 32'h110, 2, 0};
    vecs[8]  = '{1, 1, 0, 32'h118, 0, 32'h000, 0, 1};
    vecs[9]  = '{1, 1, 1, 32'h11C, 0, 32'h000, 0, 1};
    vecs[10] = '{0, 0, 0, 32'h000, 0, 32'h000, 0, 1};
    vecs[11] = '{0, 1, 1, 32'h120, 1, 32'h120, 1, 1};
    vecs[12] = '{1, 0, 1, 32'h000, 0, 32'h000, 0, 1};

    // Test 1: reset held two cycles with In_Valid=1.
    in_valid = 1'b1;
    cur = pc_beat(32'hDEAD0000);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ctrl", out_ctrl, 14'd0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_occ", out_occ, 2'd0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_no_accept", out_occ, 2'd0);
    in_valid = 1'b0;

    // Test 2: single beat with rd/func3 decode.
    cur = '0;
    cur.ctrl  = 14'h2A5;
    cur.pc    = 32'h10000000;
    cur.pcn   = 32'h10000004;
    cur.data  = 64'h0000_0000_1234_5678;
    cur.imm   = 32'h0000000F;
    cur.instr = 32'h00F00713;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_pc", out_pc, 32'h10000000);
    chk("t2_data1", out_data[31:0], 32'h12345678);
    chk("t2_wa", out_wa, 5'h0E);
    chk("t2_func3", out_f3, 3'd0);
    step();
    chk("t2_drained", out_valid, 1'b0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      flush = vecs[i].flush;
      in_valid = vecs[i].in_valid;
      out_ready = vecs[i].out_ready;
      cur = pc_beat(vecs[i].pc);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_occ", i), out_occ, vecs[i].exp_occ);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_in_ready);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
      else chk($sformatf("vec%0d_ctrl", i), out_ctrl, 14'd0);
    end
    flush = 1'b0;
    in_valid = 1'b0;

    // Test 3: fill under stall, hold, then drain in order.
    do_reset();
    a = pc_beat(32'h0000A000);
    b = pc_beat(32'h0000B000);
    out_ready = 1'b0;
    in_valid = 1'b1;
    cur = a;
    step();
    cur = b;
    step();
    in_valid = 1'b0;
    chk("t3_occ", out_occ, 2'd2);
    chk("t3_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_pc", out_pc, 32'h0000A000);
    end
    chk("t3_stall", out_cnt, 16'd6);
    chk("t3_s_stall", s_out_cnt, 3'd6);
    out_ready = 1'b1;
    step();
    chk("t3_pop_b", out_pc, 32'h0000B000);
    step();
    chk("t3_empty", out_valid, 1'b0);

    // Test 4: eight beats back-to-back.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cur = pc_beat(32'h0000C000 + 32'(4 * k));
      step();
      chk("t4_pc", out_pc, 32'h0000C000 + 32'(4 * k));
      chk("t4_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    step();

    // Test 5: flush while FULL with an incoming beat.
    out_ready = 1'b0;
    in_valid = 1'b1;
    cur = pc_beat(32'h0000D000);
    step();
    cur = pc_beat(32'h0000E000);
    step();
    chk("t5_full", out_occ, 2'd2);
    cur = pc_beat(32'h0000CCCC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_ctrl", out_ctrl, 14'd0);
    chk("t5_occ", out_occ, 2'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_c", out_valid, 1'b0);
    end

    // Test 6: saturation of the 3-bit counter, then reset mid-stall.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    cur = pc_beat(32'h0000F000);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("t6_s_sat", s_out_cnt, 3'd7);
    chk("t6_cnt", out_cnt, 16'd10);
    rst_n = 1'b0;
    step();
    check_all_zero("t6_rst");
    rst_n = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 31) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      cur = rand_beat();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
